// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared defaults and the FSM state type for the ADC serial
// responder emulator (adc_serial_emulator and adc_emu_pattern_gen).
package adc_emu_pkg;

  localparam int unsigned DATA_W_DEF     = 12;
  localparam int unsigned LEAD_ZEROS_DEF = 4;
  localparam int unsigned FRAME_W_DEF    = LEAD_ZEROS_DEF + DATA_W_DEF;
  localparam int unsigned PAT_STEP_DEF   = 1;
  localparam int unsigned CNT_W_DEF      = $clog2(FRAME_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_t;

endpackage

// File: rtl/adc_emu_pattern_gen.sv
// adc_emu_pattern_gen: ramp source for the ADC emulator. Advances by PAT_STEP
// (wrapping mod 2^DATA_W) on every cycle 'advance' is high.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high (ramp -> 0)
//   advance  step the ramp (driven by the frame-done event)
//   ramp     current ramp value
module adc_emu_pattern_gen
  import adc_emu_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned PAT_STEP = PAT_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [DATA_W-1:0] ramp
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp <= '0;
    end else if (advance) begin
      ramp <= ramp + DATA_W'(PAT_STEP);
    end
  end

endmodule

// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: synthesizable stand-in for the ADC serial responder.
// While cs_n is low it shifts out a frame of LEAD_ZEROS zero bits followed by
// a DATA_W-bit sample, MSB first. Samples come from a one-entry hold register
// fed by a valid/ready handshake; if the hold is empty at frame start the last
// completed frame value is repeated and 'underrun' pulses.
// Optional feature macro: ADC_EMU_PATTERN_EN adds pattern_sel and an internal
// ramp (adc_emu_pattern_gen) that replaces the sample source when selected.
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   cs_n          chip select from capture block, active low
//   sdata         serial data out
//   sample_i      next sample value
//   sample_valid  sample_i is valid
//   sample_ready  hold register empty
//   frame_done    1-cycle pulse after the last frame bit
//   underrun      1-cycle pulse: frame started with hold empty
//   aborted       1-cycle pulse: cs_n rose mid-frame
//   pattern_sel   (ADC_EMU_PATTERN_EN) 1 = ramp replaces sample data
module adc_serial_emulator
  import adc_emu_pkg::*;
#(
`ifdef ADC_EMU_PATTERN_EN
  parameter int unsigned PAT_STEP   = PAT_STEP_DEF,
`endif
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEAD_ZEROS = LEAD_ZEROS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  output logic              sdata,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              underrun,
  output logic              aborted
`ifdef ADC_EMU_PATTERN_EN
  ,
  input  logic              pattern_sel
`endif
);

  localparam int unsigned FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] CNT_LEAD_LAST = CNT_W'(LEAD_ZEROS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q, last_q, frame_data_q;
  logic              hold_full_q;

  logic              frame_start, done_evt, abort_evt, underrun_evt, accept;
  logic [DATA_W-1:0] frame_src;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  bit_idx;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // With a single leading zero the first low cycle already covers it.
      IDLE: if (!cs_n) state_d = (LEAD_ZEROS == 1) ? DATA : LEAD;
      LEAD: begin
        if (cs_n)                          state_d = IDLE;
        else if (cnt_q == CNT_LEAD_LAST)   state_d = DATA;
      end
      DATA: begin
        if (cs_n)                          state_d = IDLE;
        else if (cnt_q == CNT_LAST)        state_d = TAIL;
      end
      TAIL: if (cs_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / events ----------------
  assign bit_idx = CNT_LAST - cnt_q;
  assign shifted = frame_data_q >> bit_idx;

  always_comb begin
    frame_start = (state_q == IDLE) && !cs_n;
    abort_evt   = ((state_q == LEAD) || (state_q == DATA)) && cs_n;
    done_evt    = (state_q == DATA) && !cs_n && (cnt_q == CNT_LAST);
    sdata       = 1'b0;
    // Bit 0 (first low cycle, still IDLE) is always a leading zero.
    if (!cs_n && ((state_q == LEAD) || (state_q == DATA)) &&
        (cnt_q >= CNT_W'(LEAD_ZEROS)))
      sdata = shifted[0];
  end

`ifdef ADC_EMU_PATTERN_EN
  logic [DATA_W-1:0] ramp;

  adc_emu_pattern_gen #(
    .DATA_W   (DATA_W),
    .PAT_STEP (PAT_STEP)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (done_evt),
    .ramp    (ramp)
  );
`endif

  always_comb begin
    frame_src    = hold_full_q ? hold_q : last_q;
    underrun_evt = frame_start && !hold_full_q;
`ifdef ADC_EMU_PATTERN_EN
    if (pattern_sel) begin
      frame_src    = ramp;
      underrun_evt = 1'b0;
    end
`endif
  end

  assign accept       = sample_valid && !hold_full_q;
  assign sample_ready = !hold_full_q;

  // ---------------- bit counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (frame_start) begin
      cnt_q <= CNT_W'(1);
    end else if (((state_q == LEAD) || (state_q == DATA)) && !cs_n && !done_evt) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // ---------------- datapath ----------------
  // Accept only happens while hold is empty, so a same-edge frame start
  // always takes 'last' and the new sample waits in hold for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      frame_data_q <= '0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      frame_done <= done_evt;
      underrun   <= underrun_evt;
      aborted    <= abort_evt;
      if (frame_start) frame_data_q <= frame_src;
      if (done_evt)    last_q       <= frame_data_q;
      if (accept)      hold_q       <= sample_i;
      hold_full_q <= accept || (hold_full_q && !frame_start);
    end
  end

endmodule

// File: tb/tb_adc_serial_emulator.sv
module tb_adc_serial_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdata;
  logic [11:0] sample_i = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        frame_done, underrun, aborted;
`ifdef ADC_EMU_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  adc_serial_emulator #(
    .DATA_W     (12),
    .LEAD_ZEROS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cs_n         (cs_n),
    .sdata        (sdata),
    .sample_i     (sample_i),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .aborted      (aborted)
`ifdef ADC_EMU_PATTERN_EN
    ,
    .pattern_sel  (pattern_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the length of the current cs_n low run: position k of the run is
  // frame bit k (k<16), a frame value is chosen at k==0, completes at k==15,
  // and a high cycle after a run of 1..15 lows is an abort.
  int          m_run = 0;
  bit          m_on = 0;
  bit          m_full = 0;
  logic [11:0] m_hold = '0, m_last = '0, m_fv = '0, m_ramp = '0;
  bit          e_done = 0, e_under = 0, e_abort = 0;

  always @(negedge clk) begin
    logic [15:0] fvec;
    logic        exp_sd;
    bit          acc, pat;
    pat = 1'b0;
`ifdef ADC_EMU_PATTERN_EN
    pat = pattern_sel;
`endif
    if (m_on) begin
      if (!cs_n && m_run == 0) m_fv = pat ? m_ramp : (m_full ? m_hold : m_last);
      fvec   = {4'b0000, m_fv};
      exp_sd = (!cs_n && m_run < 16) ? fvec[15 - m_run] : 1'b0;
      check("sdata",        {31'd0, sdata},        {31'd0, exp_sd});
      check("sample_ready", {31'd0, sample_ready}, {31'd0, !m_full});
      check("frame_done",   {31'd0, frame_done},   {31'd0, e_done});
      check("underrun",     {31'd0, underrun},     {31'd0, e_under});
      check("aborted",      {31'd0, aborted},      {31'd0, e_abort});
    end
    if (rst) begin
      m_on = 1; m_run = 0; m_full = 0;
      m_hold = '0; m_last = '0; m_fv = '0; m_ramp = '0;
      e_done = 0; e_under = 0; e_abort = 0;
    end else if (m_on) begin
      acc = sample_valid && !m_full;
      e_done = 0; e_under = 0; e_abort = 0;
      if (cs_n) begin
        if (m_run >= 1 && m_run < 16) e_abort = 1;
        m_run = 0;
      end else begin
        if (m_run == 0) begin
          e_under = !m_full && !pat;
          m_full  = 0;
        end
        if (m_run == 15) begin
          e_done = 1;
          m_last = m_fv;
          m_ramp = m_ramp + 12'd1;
        end
        if (m_run < 1000) m_run++;
      end
      if (acc) begin
        m_hold = sample_i;
        m_full = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    bit r, ok;
    ok = 0;
    sample_valid = 1'b1;
    sample_i = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      r = sample_ready;
      step();
      if (r) ok = 1;
    end
    sample_valid = 1'b0;
    check("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  // cs_n low for nlow cycles then high for gap cycles; collects bits and pulses.
  task automatic frame(input int nlow, input int gap, output logic [31:0] bits,
                       output int nd, output int nu, output int na);
    bits = '0; nd = 0; nu = 0; na = 0;
    for (int i = 0; i < nlow + gap; i++) begin
      cs_n = (i < nlow) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (i < nlow) bits = {bits[30:0], sdata};
      nd += int'(frame_done);
      nu += int'(underrun);
      na += int'(aborted);
      step();
    end
  endtask

  initial begin
    logic [31:0] bits;
    int nd, nu, na;

    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, sample_ready}, 32'd1);
    check("reset_sdata", {31'd0, sdata}, 32'd0);
    step();

    // No push after reset: all-zero frame with underrun.
    frame(16, 3, bits, nd, nu, na);
    check("t2a_bits", bits & 32'hFFFF, 32'h0000);
    check("t2a_underrun", nu, 1);
    check("t2a_done", nd, 1);
    push(12'h5A5);
    frame(16, 3, bits, nd, nu, na);
    check("t2b_bits", bits & 32'hFFFF, 32'h05A5);
    check("t2b_underrun", nu, 0);
    frame(16, 3, bits, nd, nu, na);
    check("t2c_bits", bits & 32'hFFFF, 32'h05A5);
    check("t2c_underrun", nu, 1);

    // Basic frame.
    push(12'hABC);
    frame(16, 3, bits, nd, nu, na);
    check("t1_bits", bits & 32'hFFFF, 32'h0ABC);
    check("t1_done", nd, 1);
    check("t1_underrun", nu, 0);
    check("t1_aborted", na, 0);

    // Abort after 7 bits: 0x123 is lost, last stays 0xABC.
    push(12'h123);
    frame(7, 3, bits, nd, nu, na);
    check("t3_aborted", na, 1);
    check("t3_done", nd, 0);
    frame(16, 3, bits, nd, nu, na);
    check("t3_next_bits", bits & 32'hFFFF, 32'h0ABC);
    check("t3_next_underrun", nu, 1);

    // Overlong chip select: zeros after bit 15, one frame only.
    push(12'h3C7);
    frame(20, 3, bits, nd, nu, na);
    check("t4_bits", bits & 32'hFFFFF, 32'h03C70);
    check("t4_done", nd, 1);
    check("t4_aborted", na, 0);

    // One-cycle chip select aborts after one bit.
    frame(1, 3, bits, nd, nu, na);
    check("t4b_aborted", na, 1);

    // Back-pressure then reset mid-frame.
    push(12'h111);
    sample_valid = 1'b1;
    sample_i = 12'h222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ready_full", {31'd0, sample_ready}, 32'd0);
      step();
    end
    cs_n = 1'b0;
    @(negedge clk);
    check("t5_ready_at_start", {31'd0, sample_ready}, 32'd0);
    step();
    @(negedge clk);
    check("t5_ready_after_start", {31'd0, sample_ready}, 32'd1);
    step();
    sample_valid = 1'b0;
    @(negedge clk);
    check("t5_second_accepted", {31'd0, sample_ready}, 32'd0);
    for (int k = 2; k < 9; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_sdata", {31'd0, sdata}, 32'd0);
    check("t5_rst_ready", {31'd0, sample_ready}, 32'd1);
    cs_n = 1'b1;
    step(); step();
    frame(16, 3, bits, nd, nu, na);
    check("t5_post_rst_bits", bits & 32'hFFFF, 32'h0000);
    check("t5_post_rst_underrun", nu, 1);

`ifdef ADC_EMU_PATTERN_EN
    begin
      int bad, tot_u;
      bad = 0; tot_u = 0;
      rst = 1'b1; step(); rst = 1'b0;
      pattern_sel = 1'b1;
      for (int f = 0; f < 4097; f++) begin
        frame(16, 1, bits, nd, nu, na);
        tot_u += nu;
        if ((bits & 32'hFFFF) != (32'(f) & 32'h0FFF)) bad++;
      end
      check("t6_ramp_errors", bad, 0);
      check("t6_underrun", tot_u, 0);
      pattern_sel = 1'b0;
    end
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
